mem_lsu: RTL

//  MEM stage of the 5-stage pipeline. Consumes ex_mem outputs (rw/wreg/wdata plus memory op, address, store data)
//  and produces the register-writeback triple for mem_wb. ALU results pass straight through. Loads/stores run a
//  req/ack data-bus transaction, holding stallreq to ctrl until done. Big-endian byte lanes.

---
 rtl/mem_lsu.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM stage load/store unit: ALU passthrough, req/ack data-bus access, big-endian lanes
// Loads and stores stall the pipeline through IDLE -> BUSY -> DONE; results are presented in DONE.
module mem_lsu #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_rw,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  output logic [4:0]  wb_rw,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic        exc_misalign,
  output logic        exc_bus_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [7:0] CNT_LAST = 8'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        is_load;
  logic        is_store;
  logic        misalign;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;

  always_comb begin
    is_load  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
    is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);
    case (mem_op)
      OP_LH, OP_LHU, OP_SH: misalign = mem_addr[0];
      OP_LW, OP_SW:         misalign = (mem_addr[1:0] != 2'b00);
      default:              misalign = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data; lane 0 is the most significant byte.
  always_comb begin
    case (mem_op)
      OP_LB, OP_LBU, OP_SB: begin
        sel_c   = 4'b1000 >> mem_addr[1:0];
        wdata_c = {4{mem_sdata[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        sel_c   = mem_addr[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{mem_sdata[15:0]}};
      end
      default: begin
        sel_c   = 4'b1111;
        wdata_c = mem_sdata;
      end
    endcase
  end

  // Inputs are held by ctrl while stalled, so mem_addr/mem_op still select the lane in DONE.
  always_comb begin
    case (mem_addr[1:0])
      2'd0:    byte_lane = rdata_q[31:24];
      2'd1:    byte_lane = rdata_q[23:16];
      2'd2:    byte_lane = rdata_q[15:8];
      default: byte_lane = rdata_q[7:0];
    endcase
    half_lane = mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
    case (mem_op)
      OP_LB:   load_val = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_val = {24'd0, byte_lane};
      OP_LH:   load_val = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_val = {16'd0, half_lane};
      default: load_val = rdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if ((is_load || is_store) && !misalign) begin
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus_ack || (cnt == CNT_LAST)) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_sel   <= 4'd0;
      bus_wdata <= 32'd0;
      cnt       <= 8'd0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((is_load || is_store) && !misalign) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_sel   <= sel_c;
            bus_wdata <= wdata_c;
            cnt       <= 8'd0;
            err_q     <= 1'b0;
          end
        end
        S_BUSY: begin
          if (bus_ack) begin
            rdata_q <= bus_rdata;
            bus_req <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            bus_req <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wb_rw        = mem_rw;
    wb_wreg      = mem_wreg;
    wb_wdata     = mem_wdata;
    stallreq     = 1'b0;
    exc_misalign = 1'b0;
    exc_bus_err  = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_load || is_store) begin
          wb_wreg = 1'b0;
          if (misalign) begin
            exc_misalign = 1'b1;
          end else begin
            stallreq = 1'b1;
          end
        end
      end
      S_BUSY: begin
        stallreq = 1'b1;
        wb_wreg  = 1'b0;
      end
      default: begin
        if (err_q) begin
          wb_wreg     = 1'b0;
          exc_bus_err = 1'b1;
        end else if (is_load) begin
          wb_wdata = load_val;
        end else begin
          wb_wreg = 1'b0;
        end
      end
    endcase
  end

endmodule
